// File: rtl/fwd_hazard_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package fwd_hazard_pkg;

    localparam logic [4:0] REG_X0 = 5'd0;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } slot_tag_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Execute-stage bundle between the pipeline and the hazard unit.
// Statistics counters appear only when FWD_HAZARD_STATS_EN is defined.
interface fwd_hazard_unit_if #(
    parameter int XLEN    = 64,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3
);
    localparam int SELW = fwd_hazard_pkg::sel_width(DEPTH);

    logic                      ext_stall;
    logic                      flush;
    logic                      ex_valid;
    logic [4:0]                ex_rd;
    logic                      ex_reg_write;
    logic                      ex_is_load;
    logic [NUM_SRC*5-1:0]      ex_rs;
    logic [NUM_SRC-1:0]        ex_rs_used;
    logic [NUM_SRC*XLEN-1:0]   ex_rs_value;
    logic [DEPTH*XLEN-1:0]     stage_data;
    logic [NUM_SRC*XLEN-1:0]   fwd_value;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;
    logic                      stall;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0]               fwd_count;
    logic [31:0]               stall_cycles;
    logic [31:0]               stall_events;
`endif

    modport master (
        output ext_stall, flush, ex_valid, ex_rd, ex_reg_write, ex_is_load,
        output ex_rs, ex_rs_used, ex_rs_value, stage_data,
`ifdef FWD_HAZARD_STATS_EN
        input  fwd_count, stall_cycles, stall_events,
`endif
        input  fwd_value, fwd_sel, stall
    );

    modport slave (
        input  ext_stall, flush, ex_valid, ex_rd, ex_reg_write, ex_is_load,
        input  ex_rs, ex_rs_used, ex_rs_value, stage_data,
`ifdef FWD_HAZARD_STATS_EN
        output fwd_count, stall_cycles, stall_events,
`endif
        output fwd_value, fwd_sel, stall
    );

endinterface

// File: rtl/fwd_src_sel.sv
// Per-operand producer selection: youngest matching slot wins, x0 never forwards.
module fwd_src_sel
    import fwd_hazard_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int SELW       = sel_width(DEPTH)
) (
    input  slot_tag_t [DEPTH-1:0] i_slots,
    input  logic                  i_ex_valid,
    input  logic [4:0]            i_rs,
    input  logic                  i_used,
    input  logic [XLEN-1:0]       i_rf_value,
    input  logic [DEPTH*XLEN-1:0] i_stage_data,
    output logic [SELW-1:0]       o_sel,
    output logic [XLEN-1:0]       o_value,
    output logic                  o_hazard
);

    // Walk oldest to youngest so the lowest matching slot overrides.
    always_comb begin
        o_sel    = '0;
        o_value  = i_rf_value;
        o_hazard = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (i_slots[k-1].valid && i_slots[k-1].reg_write &&
                (i_slots[k-1].rd == i_rs) && (i_rs != REG_X0) &&
                i_used && i_ex_valid) begin
                o_sel    = SELW'(k);
                o_value  = i_stage_data[(k-1)*XLEN +: XLEN];
                o_hazard = i_slots[k-1].is_load && (k < LOAD_READY);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: slot shadow pipeline, stall FSM, operand muxes.
// Optional counters enabled by defining FWD_HAZARD_STATS_EN.
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2
) (
    input logic               clk,
    input logic               reset,
    fwd_hazard_unit_if.slave  bus
);

    localparam int SELW = sel_width(DEPTH);

    slot_tag_t [DEPTH-1:0]              r_slots;
    fsm_state_t                         r_state;
    fsm_state_t                         w_state_next;
    logic [NUM_SRC-1:0][SELW-1:0]       w_sel;
    logic [NUM_SRC-1:0][XLEN-1:0]       w_value;
    logic [NUM_SRC-1:0]                 w_hazard;
    logic                               w_stall;
    logic                               w_advance;
    slot_tag_t                          w_new_slot;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_sel #(
            .XLEN       (XLEN),
            .DEPTH      (DEPTH),
            .LOAD_READY (LOAD_READY),
            .SELW       (SELW)
        ) u_sel (
            .i_slots      (r_slots),
            .i_ex_valid   (bus.ex_valid),
            .i_rs         (bus.ex_rs[5*i +: 5]),
            .i_used       (bus.ex_rs_used[i]),
            .i_rf_value   (bus.ex_rs_value[i*XLEN +: XLEN]),
            .i_stage_data (bus.stage_data),
            .o_sel        (w_sel[i]),
            .o_value      (w_value[i]),
            .o_hazard     (w_hazard[i])
        );
    end

    assign w_advance     = ~bus.ext_stall;
    assign w_stall       = (|w_hazard) & ~bus.flush;
    assign bus.stall     = w_stall;
    assign bus.fwd_sel   = w_sel;
    assign bus.fwd_value = w_value;

    // A stalled or flushed EX instruction enters slot 1 as a bubble.
    assign w_new_slot = '{valid:     bus.ex_valid & ~bus.flush & ~w_stall,
                          rd:        bus.ex_rd,
                          reg_write: bus.ex_reg_write,
                          is_load:   bus.ex_is_load};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slots <= '0;
        end else if (w_advance) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_slots[k] <= r_slots[k-1];
            end
            r_slots[0] <= w_new_slot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.flush) begin
            w_state_next = RUN;
        end else if (w_advance) begin
            w_state_next = w_stall ? STALL : RUN;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic        w_stall_start;
    logic [31:0] r_fwd_count;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_stall_events;

    assign w_stall_start = (r_state == RUN) && w_stall && w_advance;

    // Saturating counters; they never wrap back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd_count    <= '0;
            r_stall_cycles <= '0;
            r_stall_events <= '0;
        end else begin
            if (w_advance && (|w_sel) && (r_fwd_count != '1))
                r_fwd_count <= r_fwd_count + 32'd1;
            if (w_stall && w_advance && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_stall_start && (r_stall_events != '1))
                r_stall_events <= r_stall_events + 32'd1;
        end
    end

    assign bus.fwd_count    = r_fwd_count;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.stall_events = r_stall_events;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed vectors push expectations, a monitor compares.
module tb_fwd_hazard_unit;

    localparam int XLEN = 64;

    typedef struct {
        string       name;
        int          cyc;
        logic [1:0]  sel0;
        logic [1:0]  sel1;
        logic [63:0] v0;
        logic [63:0] v1;
        logic        stall;
        bit          chkVal;
        bit          chkStats;
        int          fc;
        int          sc;
        int          se;
    } exp_t;

    logic clk;
    logic reset;
    int   cycleCnt;
    int   checks;
    int   passes;
    exp_t expQ[$];

    fwd_hazard_unit_if #(.XLEN(XLEN), .NUM_SRC(2), .DEPTH(3)) bus ();

    fwd_hazard_unit #(
        .XLEN(XLEN), .NUM_SRC(2), .DEPTH(3), .LOAD_READY(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic void cmp(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    endfunction

    // Drive one EX vector just after the rising edge.
    task automatic applyStimulus(input logic rst, input logic valid, input logic [4:0] rd,
                                 input logic rw, input logic ld, input logic [4:0] rs0,
                                 input logic [4:0] rs1, input logic [1:0] used,
                                 input logic [63:0] rv0, input logic [63:0] rv1,
                                 input logic [63:0] sd1, input logic [63:0] sd2,
                                 input logic [63:0] sd3, input logic fl, input logic ext);
        @(posedge clk);
        #1;
        reset            = rst;
        bus.ex_valid     = valid;
        bus.ex_rd        = rd;
        bus.ex_reg_write = rw;
        bus.ex_is_load   = ld;
        bus.ex_rs        = {rs1, rs0};
        bus.ex_rs_used   = used;
        bus.ex_rs_value  = {rv1, rv0};
        bus.stage_data   = {sd3, sd2, sd1};
        bus.flush        = fl;
        bus.ext_stall    = ext;
    endtask

    // Queue the expected response for the cycle just driven.
    task automatic checkOutput(input string name, input logic [1:0] s0, input logic [1:0] s1,
                               input logic [63:0] v0, input logic [63:0] v1, input logic st,
                               input bit chkVal, input bit chkStats = 0,
                               input int fc = 0, input int sc = 0, input int se = 0);
        exp_t e;
        e.name = name; e.cyc = cycleCnt; e.sel0 = s0; e.sel1 = s1;
        e.v0 = v0; e.v1 = v1; e.stall = st; e.chkVal = chkVal;
        e.chkStats = chkStats; e.fc = fc; e.sc = sc; e.se = se;
        expQ.push_back(e);
    endtask

    // Monitor: compares every due expectation at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0 && expQ[0].cyc <= cycleCnt) begin
                e = expQ.pop_front();
                if (e.cyc < cycleCnt) begin
                    checks++;
                    $display("[TB] FAIL %s_late actual_cycle=%0d required_cycle=%0d",
                             e.name, cycleCnt, e.cyc);
                end else begin
                    cmp({e.name, "_stall"}, 64'(bus.stall), 64'(e.stall));
                    cmp({e.name, "_sel0"}, 64'(bus.fwd_sel[1:0]), 64'(e.sel0));
                    cmp({e.name, "_sel1"}, 64'(bus.fwd_sel[3:2]), 64'(e.sel1));
                    if (e.chkVal) begin
                        cmp({e.name, "_val0"}, bus.fwd_value[63:0], e.v0);
                        cmp({e.name, "_val1"}, bus.fwd_value[127:64], e.v1);
                    end
`ifdef FWD_HAZARD_STATS_EN
                    if (e.chkStats) begin
                        cmp({e.name, "_fwd_count"}, 64'(bus.fwd_count), 64'(e.fc));
                        cmp({e.name, "_stall_cycles"}, 64'(bus.stall_cycles), 64'(e.sc));
                        cmp({e.name, "_stall_events"}, 64'(bus.stall_events), 64'(e.se));
                    end
`endif
                end
            end
        end
    end

    initial begin
        int waitCycles;
        reset = 1'b1;
        bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_reg_write = 0; bus.ex_is_load = 0;
        bus.ex_rs = '0; bus.ex_rs_used = '0; bus.ex_rs_value = '0; bus.stage_data = '0;
        bus.flush = 0; bus.ext_stall = 0;
        repeat (2) @(posedge clk);

        // add x5 right after reset: nothing in flight
        applyStimulus(0, 1, 5, 1, 0, 1, 2, 2'b11, 64'h111, 64'h222, 64'h1, 64'h2, 64'h3, 0, 0);
        checkOutput("reset_state", 0, 0, 64'h111, 64'h222, 0, 1);
        // sub x6,x5,x7: x5 from slot 1
        applyStimulus(0, 1, 6, 1, 0, 5, 7, 2'b11, 64'h50, 64'h70, 64'h10, 64'h2, 64'h3, 0, 0);
        checkOutput("alu_b2b", 1, 0, 64'h10, 64'h70, 0, 1);
        // writes x5; reads x5 (slot 2) and x6 (slot 1)
        applyStimulus(0, 1, 5, 1, 0, 5, 6, 2'b11, 64'h1, 64'h2, 64'hCC, 64'hBB, 64'h3, 0, 0);
        checkOutput("two_slots", 2, 1, 64'hBB, 64'hCC, 0, 1);
        // writes x5 again; x5 now in slot 1 and slot 3
        applyStimulus(0, 1, 5, 1, 0, 5, 5, 2'b11, 64'h1, 64'h2, 64'hAA, 64'hDD, 64'hBB, 0, 0);
        checkOutput("youngest_13", 1, 1, 64'hAA, 64'hAA, 0, 1);
        // writes x0; x5 in slots 1 and 2, x6 in slot 3
        applyStimulus(0, 1, 0, 1, 0, 5, 6, 2'b11, 64'h1, 64'h2, 64'hAA, 64'hBB, 64'hEE, 0, 0);
        checkOutput("youngest_12", 1, 3, 64'hAA, 64'hEE, 0, 1);
        // rs0 = x0 with an x0 writer in slot 1, rs1 unused
        applyStimulus(0, 1, 9, 0, 0, 0, 5, 2'b01, 64'h123, 64'h456, 64'h7, 64'h8, 64'h9, 0, 0);
        checkOutput("x0_unused", 0, 0, 64'h123, 64'h456, 0, 1);
        // ld x8; rs0 = x9 whose producer does not write
        applyStimulus(0, 1, 8, 1, 1, 9, 3, 2'b11, 64'h9, 64'h3, 64'h7, 64'h8, 64'h9, 0, 0);
        checkOutput("no_regwrite", 0, 0, 64'h9, 64'h3, 0, 1);
        // add x8,x8,x8: load in slot 1 -> stall
        applyStimulus(0, 1, 8, 1, 0, 8, 8, 2'b11, 64'h1, 64'h2, 64'h5, 64'h6, 64'h7, 0, 0);
        checkOutput("load_use_stall", 1, 1, 0, 0, 1, 0);
        applyStimulus(0, 1, 8, 1, 0, 8, 8, 2'b11, 64'h1, 64'h2, 64'h5, 64'h88, 64'h7, 0, 0);
        checkOutput("load_use_fwd", 2, 2, 64'h88, 64'h88, 0, 1);
        // ld x12 then a dependent op that gets flushed
        applyStimulus(0, 1, 12, 1, 1, 0, 0, 2'b00, 64'h1, 64'h2, 64'h5, 64'h6, 64'h7, 0, 0);
        checkOutput("ld12", 0, 0, 64'h1, 64'h2, 0, 1);
        applyStimulus(0, 1, 13, 1, 0, 12, 0, 2'b01, 64'h1, 64'h2, 64'h1212, 64'h6, 64'h7, 1, 0);
        checkOutput("flush_wins", 1, 0, 64'h1212, 64'h2, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 12, 13, 2'b11, 64'h1, 64'h2, 64'h5, 64'h2222, 64'h7, 0, 0);
        checkOutput("flush_bubble", 2, 0, 64'h2222, 64'h2, 0, 1);
        // ld x14 then dependent op frozen by ext_stall for 3 cycles
        applyStimulus(0, 1, 14, 1, 1, 0, 0, 2'b00, 64'h1, 64'h2, 64'h5, 64'h6, 64'h7, 0, 0);
        checkOutput("ld14", 0, 0, 64'h1, 64'h2, 0, 1);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(0, 1, 15, 1, 0, 14, 0, 2'b01, 64'h1, 64'h2, 64'h5, 64'h6, 64'h7, 0, 1);
            checkOutput($sformatf("ext_hold%0d", n), 1, 0, 0, 0, 1, 0, 1, 8, 1, 1);
        end
        applyStimulus(0, 1, 15, 1, 0, 14, 0, 2'b01, 64'h1, 64'h2, 64'h5, 64'h6, 64'h7, 0, 0);
        checkOutput("ext_release", 1, 0, 0, 0, 1, 0, 1, 8, 1, 1);
        applyStimulus(0, 1, 15, 1, 0, 14, 0, 2'b01, 64'h1, 64'h2, 64'h5, 64'h1414, 64'h7, 0, 0);
        checkOutput("ext_fwd", 2, 0, 64'h1414, 64'h2, 0, 1, 1, 9, 2, 2);
        // ld x16, dependent op stalls while reset is asserted
        applyStimulus(0, 1, 16, 1, 1, 0, 0, 2'b00, 64'h1, 64'h2, 64'h5, 64'h6, 64'h7, 0, 0);
        checkOutput("ld16", 0, 0, 64'h1, 64'h2, 0, 1);
        applyStimulus(1, 1, 17, 1, 0, 16, 0, 2'b01, 64'h31, 64'h32, 64'h5, 64'h6, 64'h7, 0, 0);
        checkOutput("pre_reset_stall", 1, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 17, 1, 0, 16, 0, 2'b01, 64'h31, 64'h32, 64'h5, 64'h6, 64'h7, 0, 0);
        checkOutput("post_reset", 0, 0, 64'h31, 64'h32, 0, 1, 1, 0, 0, 0);

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain actual_pending=%0d required_pending=0", expQ.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
